// File: rtl/layer2_argmax.sv
// rtl/layer2_argmax.sv - MNIST MLP output layer: time-multiplexed MAC over ROM weights, then sequential argmax
module layer2_argmax #(
  parameter int N_IN   = 64,
  parameter int N_OUT  = 10,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*N_IN-1:0]    inputLayer,
  output logic [ADDR_W-1:0]     weight_addr,
  input  logic [15:0]           weight_data,
  output logic                  busy,
  output logic                  done,
  output logic [16*N_OUT-1:0]   outputLayer,
  output logic [IDX_W-1:0]      class_idx
);

  localparam int CNT_W = $clog2(N_IN + N_OUT + 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ARGMAX, S_SELECT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          j_q, j_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [16*N_IN-1:0]        in_q, in_d;
  logic [16*N_OUT-1:0]       out_q, out_d;
  logic signed [15:0]        best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          class_q, class_d;

  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [15:0]        score;
  logic signed [15:0]        cur;
  int                        in_k;
  int                        out_k;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    base_d     = base_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    in_d       = in_q;
    out_d      = out_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;

    // ROM data in MAC cycle c belongs to the address issued in cycle c-1
    in_k = int'(cnt_q) - 1;
    if (in_k < 0) in_k = 0;
    if (in_k > N_IN - 1) in_k = N_IN - 1;
    out_k = int'(cnt_q);
    if (out_k > N_OUT - 1) out_k = N_OUT - 1;

    prod    = $signed(in_q[16*in_k +: 16]) * $signed(weight_data);
    sum     = acc_q + (ACC_W'($signed(weight_data)) <<< FRAC);
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX)      score = 16'sh7FFF;
    else if (shifted < SAT_MIN) score = 16'sh8000;
    else                        score = shifted[15:0];
    cur = out_q[16*out_k +: 16];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = inputLayer;
          acc_d   = '0;
          j_d     = '0;
          base_d  = '0;
          cnt_d   = '0;
          addr_d  = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0 && int'(cnt_q) <= N_IN) acc_d = acc_q + ACC_W'(prod);
        if (int'(cnt_q) < N_IN) addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
        if (int'(cnt_q) == N_IN + 1) begin
          out_d[16*int'(j_q) +: 16] = score;
          acc_d = '0;
          cnt_d = '0;
          if (int'(j_q) == N_OUT - 1) begin
            state_d = S_ARGMAX;
          end else begin
            j_d    = j_q + IDX_W'(1);
            base_d = base_q + ADDR_W'(N_IN + 1);
            addr_d = base_q + ADDR_W'(N_IN + 1);
          end
        end
      end
      S_ARGMAX: begin
        // strict compare keeps the lowest index on ties
        if (cnt_q == '0 || cur > best_q) begin
          best_d     = cur;
          best_idx_d = IDX_W'(cnt_q);
        end
        if (int'(cnt_q) == N_OUT - 1) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SELECT: begin
        class_d = best_idx_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      j_q        <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      in_q       <= '0;
      out_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      in_q       <= in_d;
      out_q      <= out_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
    end
  end

  assign weight_addr = addr_q;
  assign busy        = (state_q == S_MAC) || (state_q == S_ARGMAX) || (state_q == S_SELECT);
  assign done        = (state_q == S_DONE);
  assign outputLayer = out_q;
  assign class_idx   = class_q;

endmodule

// File: tb/tb_layer2_argmax.sv
// tb/tb_layer2_argmax.sv - scoreboard bench for layer2_argmax with N_IN=4, N_OUT=3
module tb_layer2_argmax;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 3;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = 4;
  localparam int LAT    = 22;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [16*N_IN-1:0]   inputLayer = '0;
  logic [ADDR_W-1:0]    weight_addr;
  logic [15:0]          weight_data = '0;
  logic                 busy;
  logic                 done;
  logic [16*N_OUT-1:0]  outputLayer;
  logic [IDX_W-1:0]     class_idx;

  logic [15:0] rom [0:14];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_low = 0;
  bit chk_done_low = 1'b0;

  typedef struct {
    logic [47:0] outs;
    logic [3:0]  cls;
    int          sc;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  layer2_argmax #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(8), .ACC_W(40), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .inputLayer(inputLayer),
    .weight_addr(weight_addr), .weight_data(weight_data), .busy(busy), .done(done),
    .outputLayer(outputLayer), .class_idx(class_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) weight_data <= (int'(weight_addr) < 15) ? rom[int'(weight_addr)] : 16'h0000;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_done_low) begin
      check("done_width", {47'd0, done}, 48'd0);
      chk_done_low = 1'b0;
    end
    if (done) begin
      chk_done_low = 1'b1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: done=1, expected 0", cyc);
      end else begin
        e = sbq.pop_front();
        check("out0", {32'd0, outputLayer[15:0]},  {32'd0, e.outs[15:0]});
        check("out1", {32'd0, outputLayer[31:16]}, {32'd0, e.outs[31:16]});
        check("out2", {32'd0, outputLayer[47:32]}, {32'd0, e.outs[47:32]});
        check("class_idx", {44'd0, class_idx}, {44'd0, e.cls});
        check("latency", 48'(cyc - e.sc), 48'(LAT));
        check("busy_low_cycles", 48'(busy_low), 48'd0);
        busy_low = 0;
      end
    end else if (sbq.size() > 0 && cyc >= sbq[0].sc && !busy) begin
      busy_low++;
    end
  end

  task automatic set_neuron(input int j, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < N_IN; k++) rom[j*(N_IN+1)+k] = w;
    rom[j*(N_IN+1)+N_IN] = b;
  endtask

  task automatic set_inputs(input logic [15:0] v);
    for (int k = 0; k < N_IN; k++) inputLayer[16*k +: 16] = v;
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic launch(input logic [47:0] outs, input logic [3:0] cls, output int es);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    es = cyc;
    x.outs = outs;
    x.cls  = cls;
    x.sc   = es;
    sbq.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 100 cycles, expected done at latency %0d", LAT);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [47:0] outs, input logic [3:0] cls);
    int es;
    launch(outs, cls, es);
    drain();
  endtask

  initial begin
    int es;
    for (int a = 0; a < 15; a++) rom[a] = 16'h0000;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {47'd0, busy}, 48'd0);
    check("rst_done", {47'd0, done}, 48'd0);
    check("rst_addr", {38'd0, weight_addr}, 48'd0);
    check("rst_class", {44'd0, class_idx}, 48'd0);
    check("rst_outputs", outputLayer, 48'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_inputs(16'h0100);
    set_neuron(0, 16'h0100, 16'h0000);
    set_neuron(1, 16'h0080, 16'h0100);
    set_neuron(2, 16'h0000, 16'h0000);
    run({16'h0000, 16'h0300, 16'h0400}, 4'd0);

    set_neuron(0, 16'hFF00, 16'h0000);
    set_neuron(2, 16'h0200, 16'h0000);
    run({16'h0800, 16'h0300, 16'hFC00}, 4'd2);

    set_inputs(16'h7FFF);
    for (int j = 0; j < N_OUT; j++) set_neuron(j, 16'h7FFF, 16'h7FFF);
    run({16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'd0);

    set_neuron(0, 16'h8000, 16'h8000);
    set_neuron(2, 16'h8000, 16'h8000);
    run({16'h8000, 16'h7FFF, 16'h8000}, 4'd1);

    set_inputs(16'h0100);
    for (int j = 0; j < N_OUT; j++) set_neuron(j, 16'h0080, 16'h0000);
    run({16'h0200, 16'h0200, 16'h0200}, 4'd0);

    set_neuron(0, 16'h0040, 16'h0000);
    run({16'h0200, 16'h0200, 16'h0100}, 4'd1);

    set_neuron(0, 16'h0100, 16'h0000);
    set_neuron(1, 16'h0080, 16'h0100);
    set_neuron(2, 16'h0000, 16'h0000);
    launch({16'h0000, 16'h0300, 16'h0400}, 4'd0, es);
    at_cycle(es + 3);
    set_inputs(16'h0200);
    at_cycle(es + 5);
    start = 1'b1;
    at_cycle(es + 6);
    start = 1'b0;
    at_cycle(es + 21);
    start = 1'b1;
    at_cycle(es + 23);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    set_inputs(16'h0100);

    set_neuron(0, 16'hFF00, 16'h0000);
    set_neuron(2, 16'h0200, 16'h0000);
    launch({16'h0800, 16'h0300, 16'hFC00}, 4'd2, es);
    at_cycle(es + 10);
    #2 rst = 1'b1;
    sbq.delete();
    busy_low = 0;
    #1;
    check("midrst_busy", {47'd0, busy}, 48'd0);
    check("midrst_done", {47'd0, done}, 48'd0);
    check("midrst_class", {44'd0, class_idx}, 48'd0);
    check("midrst_outputs", outputLayer, 48'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    run({16'h0800, 16'h0300, 16'hFC00}, 4'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
